// File: rtl/svd_compose.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : svd_compose  (plus combinational F_mult / F_add helpers)
// Brief   : A = U * diag(sigma1, sigma2) * V^T for 2x2 single-precision SVD
//           factors; optional NaN/Inf screening via SVD_COMPOSE_NAN_CHECK_EN.
// Revision: 1.0
//------------------------------------------------------------------------------

module F_mult (
  input  logic        clk,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] q
);
  localparam logic [31:0] c_qnan = 32'h7FC0_0000;

  logic              w_unused_clk;
  logic              w_sign, w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic              w_rnd;
  logic [47:0]       w_prod, w_norm;
  logic [24:0]       w_mant;
  logic [22:0]       w_frac;
  logic signed [9:0] w_exp;

  // Zero-latency model: the clock pin exists for drop-in compatibility only.
  assign w_unused_clk = clk;

  always_comb begin
    w_sign   = a[31] ^ b[31];
    w_a_zero = (a[30:23] == 8'd0);
    w_b_zero = (b[30:23] == 8'd0);
    w_a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    w_b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    w_a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    w_b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    w_prod   = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    w_norm   = w_prod[47] ? w_prod : {w_prod[46:0], 1'b0};
    // Round to nearest, ties to even.
    w_rnd    = w_norm[23] & ((|w_norm[22:0]) | w_norm[24]);
    w_mant   = {1'b0, w_norm[47:24]} + {24'd0, w_rnd};
    w_frac   = w_mant[24] ? w_mant[23:1] : w_mant[22:0];
    w_exp    = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127
             + $signed({9'd0, w_prod[47]}) + $signed({9'd0, w_mant[24]});

    if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero))
      q = c_qnan;
    else if (w_a_inf || w_b_inf || (w_exp >= 10'sd255))
      q = {w_sign, 8'hFF, 23'd0};
    else if (w_a_zero || w_b_zero || (w_exp <= 10'sd0))
      q = {w_sign, 31'd0};
    else
      q = {w_sign, w_exp[7:0], w_frac};
  end
endmodule

module F_add (
  input  logic        clk,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] q
);
  localparam logic [31:0] c_qnan = 32'h7FC0_0000;

  logic              w_unused_clk;
  logic              w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic              w_swap, w_rnd;
  logic [31:0]       w_x, w_y;
  logic [7:0]        w_d;
  logic [53:0]       w_ysh;
  logic [26:0]       w_xal, w_yal, w_m;
  logic [27:0]       w_sum;
  logic [4:0]        w_lz;
  logic [24:0]       w_mant;
  logic [22:0]       w_frac;
  logic signed [9:0] w_e0, w_exp;

  assign w_unused_clk = clk;

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && v[i]) found = 1'b1;
      else if (!found)    n = n + 5'd1;
    end
    return n;
  endfunction

  always_comb begin
    w_a_zero = (a[30:23] == 8'd0);
    w_b_zero = (b[30:23] == 8'd0);
    w_a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    w_b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    w_a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    w_b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    // x is the operand of larger magnitude; y is aligned to it with a sticky bit.
    w_swap   = (b[30:0] > a[30:0]);
    w_x      = w_swap ? b : a;
    w_y      = w_swap ? a : b;
    w_d      = w_x[30:23] - w_y[30:23];
    w_ysh    = {1'b1, w_y[22:0], 30'd0} >> w_d[4:0];
    w_yal    = (w_d > 8'd31) ? 27'd1 : {w_ysh[53:28], |w_ysh[27:0]};
    w_xal    = {1'b1, w_x[22:0], 3'b000};
    w_sum    = (w_x[31] ^ w_y[31]) ? ({1'b0, w_xal} - {1'b0, w_yal})
                                   : ({1'b0, w_xal} + {1'b0, w_yal});
    w_lz     = lzc27(w_sum[26:0]);
    w_m      = w_sum[27] ? {w_sum[27:2], w_sum[1] | w_sum[0]} : (w_sum[26:0] << w_lz);
    w_rnd    = w_m[2] & (w_m[1] | w_m[0] | w_m[3]);
    w_mant   = {1'b0, w_m[26:3]} + {24'd0, w_rnd};
    w_frac   = w_mant[24] ? w_mant[23:1] : w_mant[22:0];
    w_e0     = $signed({2'b00, w_x[30:23]}) + $signed({9'd0, w_sum[27]})
             - $signed({5'd0, (w_sum[27] ? 5'd0 : w_lz)});
    w_exp    = w_e0 + $signed({9'd0, w_mant[24]});

    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (a[31] != b[31])))
      q = c_qnan;
    else if (w_a_inf)
      q = a;
    else if (w_b_inf)
      q = b;
    else if (w_a_zero && w_b_zero)
      q = {a[31] & b[31], 31'd0};
    else if (w_b_zero)
      q = a;
    else if (w_a_zero)
      q = b;
    else if (w_sum == 28'd0)
      q = 32'd0;
    else if (w_exp >= 10'sd255)
      q = {w_x[31], 8'hFF, 23'd0};
    else if (w_exp <= 10'sd0)
      q = {w_x[31], 31'd0};
    else
      q = {w_x[31], w_exp[7:0], w_frac};
  end
endmodule

module svd_compose (
  input  logic        aclk,
  input  logic        areset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] u11,
  input  logic [31:0] u12,
  input  logic [31:0] u21,
  input  logic [31:0] u22,
  input  logic [31:0] sigma1,
  input  logic [31:0] sigma2,
  input  logic [31:0] c,
  input  logic [31:0] s,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] a11,
  output logic [31:0] a12,
  output logic [31:0] a21,
  output logic [31:0] a22,
  output logic        err
);
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SCALE0 = 3'd1,
    SCALE1 = 3'd2,
    ROT0   = 3'd3,
    ROT1   = 3'd4,
    ROT2   = 3'd5,
    ROT3   = 3'd6,
    DONE   = 3'd7
  } state_t;

  state_t      r_state, w_next;
  logic [31:0] r_u11, r_u12, r_u21, r_u22, r_sigma1, r_sigma2, r_c, r_s;
  logic [31:0] r_w11, r_w12, r_w21, r_w22;
  logic [31:0] r_a11, r_a12, r_a21, r_a22;
  logic [31:0] w_ma0, w_mb0, w_ma1, w_mb1, w_p0, w_p1, w_sum, w_res, w_neg_s;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = SCALE0;
      end
      SCALE0:  w_next = SCALE1;
      SCALE1:  w_next = ROT0;
      ROT0:    w_next = ROT1;
      ROT1:    w_next = ROT2;
      ROT2:    w_next = ROT3;
      ROT3:    w_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_neg_s = {~r_s[31], r_s[30:0]};

  // Operand routing for the two shared multipliers; the adder always sums them.
  always_comb begin
    w_ma0 = 32'd0;
    w_mb0 = 32'd0;
    w_ma1 = 32'd0;
    w_mb1 = 32'd0;
    case (r_state)
      SCALE0: begin w_ma0 = r_u11; w_mb0 = r_sigma1; w_ma1 = r_u21; w_mb1 = r_sigma1; end
      SCALE1: begin w_ma0 = r_u12; w_mb0 = r_sigma2; w_ma1 = r_u22; w_mb1 = r_sigma2; end
      ROT0:   begin w_ma0 = r_w11; w_mb0 = r_c;      w_ma1 = r_w12; w_mb1 = r_s;      end
      ROT1:   begin w_ma0 = r_w11; w_mb0 = w_neg_s;  w_ma1 = r_w12; w_mb1 = r_c;      end
      ROT2:   begin w_ma0 = r_w21; w_mb0 = r_c;      w_ma1 = r_w22; w_mb1 = r_s;      end
      ROT3:   begin w_ma0 = r_w21; w_mb0 = w_neg_s;  w_ma1 = r_w22; w_mb1 = r_c;      end
      default: ;
    endcase
  end

  F_mult u_mult0 (.clk(1'b0), .a(w_ma0), .b(w_mb0), .q(w_p0));
  F_mult u_mult1 (.clk(1'b0), .a(w_ma1), .b(w_mb1), .q(w_p1));
  F_add  u_add   (.clk(1'b0), .a(w_p0),  .b(w_p1),  .q(w_sum));

`ifdef SVD_COMPOSE_NAN_CHECK_EN
  localparam logic [31:0] c_qnan = 32'h7FC0_0000;

  logic r_nan, r_err;

  // A non-finite operand poisons every output of the transaction.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_nan <= 1'b0;
      r_err <= 1'b0;
    end else begin
      if (r_state == IDLE && in_valid)
        r_nan <= (u11[30:23] == 8'hFF) || (u12[30:23] == 8'hFF) ||
                 (u21[30:23] == 8'hFF) || (u22[30:23] == 8'hFF) ||
                 (sigma1[30:23] == 8'hFF) || (sigma2[30:23] == 8'hFF) ||
                 (c[30:23] == 8'hFF) || (s[30:23] == 8'hFF);
      if (r_state == ROT3)
        r_err <= r_nan;
      else if (r_state == DONE && out_ready)
        r_err <= 1'b0;
    end
  end

  assign err   = r_err;
  assign w_res = r_nan ? c_qnan : w_sum;
`else
  assign err   = 1'b0;
  assign w_res = w_sum;
`endif

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_u11 <= 32'h0; r_u12 <= 32'h0; r_u21 <= 32'h0; r_u22 <= 32'h0;
      r_sigma1 <= 32'h0; r_sigma2 <= 32'h0; r_c <= 32'h0; r_s <= 32'h0;
      r_w11 <= 32'h0; r_w12 <= 32'h0; r_w21 <= 32'h0; r_w22 <= 32'h0;
      r_a11 <= 32'h0; r_a12 <= 32'h0; r_a21 <= 32'h0; r_a22 <= 32'h0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_u11 <= u11; r_u12 <= u12; r_u21 <= u21; r_u22 <= u22;
          r_sigma1 <= sigma1; r_sigma2 <= sigma2; r_c <= c; r_s <= s;
        end
        SCALE0: begin r_w11 <= w_p0; r_w21 <= w_p1; end
        SCALE1: begin r_w12 <= w_p0; r_w22 <= w_p1; end
        ROT0:   r_a11 <= w_res;
        ROT1:   r_a12 <= w_res;
        ROT2:   r_a21 <= w_res;
        ROT3:   r_a22 <= w_res;
        default: ;
      endcase
    end
  end

  assign a11 = r_a11;
  assign a12 = r_a12;
  assign a21 = r_a21;
  assign a22 = r_a22;

endmodule
`default_nettype wire

// File: tb/tb_svd_compose.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_svd_compose
// Brief   : Self-checking bench; reference is the matrix product U*S*V^T in reals.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_svd_compose;
  logic        aclk = 1'b0;
  logic        areset, in_valid, in_ready, out_valid, out_ready, err;
  logic [31:0] u11, u12, u21, u22, sigma1, sigma2, c, s;
  logic [31:0] a11, a12, a21, a22;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] m_b [8];   // u11,u12,u21,u22,sigma1,sigma2,c,s
  logic [31:0] x_a [4];   // expected a11,a12,a21,a22
  logic        x_err;
  logic [31:0] o_a [4];   // observed outputs of the last transaction

  always #5 aclk = ~aclk;

  svd_compose dut (
    .aclk(aclk), .areset(areset), .in_valid(in_valid), .in_ready(in_ready),
    .u11(u11), .u12(u12), .u21(u21), .u22(u22),
    .sigma1(sigma1), .sigma2(sigma2), .c(c), .s(s),
    .out_valid(out_valid), .out_ready(out_ready),
    .a11(a11), .a12(a12), .a21(a21), .a22(a22), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // real -> single, round to nearest even (normal range only)
  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    logic [24:0] m;
    logic        rnd;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e   = d[62:52] - 11'd896;
    rnd = d[28] & ((|d[27:0]) | d[29]);
    m   = {2'b01, d[51:29]} + {24'd0, rnd};
    if (m[24]) e = e + 11'd1;
    return {d[63], e[7:0], (m[24] ? m[23:1] : m[22:0])};
  endfunction

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    logic [10:0] e;
    if (f[30:0] == 31'd0) d = {f[31], 63'd0};
    else begin
      e = {3'd0, f[30:23]} + 11'd896;
      d = {f[31], e, f[22:0], 29'd0};
    end
    return $bitstoreal(d);
  endfunction

  // A[i][j] = sum_k U[i][k] * sigma[k] * V[j][k], with V = [[c, s], [-s, c]]
  function automatic logic [31:0] ref_elem(input int i, input int j);
    real um [2][2];
    real sg [2];
    real v  [2][2];
    um[0][0] = f2r(m_b[0]); um[0][1] = f2r(m_b[1]);
    um[1][0] = f2r(m_b[2]); um[1][1] = f2r(m_b[3]);
    sg[0] = f2r(m_b[4]); sg[1] = f2r(m_b[5]);
    v[0][0] = f2r(m_b[6]); v[0][1] = f2r(m_b[7]);
    v[1][0] = f2r(m_b[7] ^ 32'h8000_0000); v[1][1] = f2r(m_b[6]);
    return r2f((um[i][0] * sg[0]) * v[j][0] + (um[i][1] * sg[1]) * v[j][1]);
  endfunction

  task automatic model_expect();
    x_a[0] = ref_elem(0, 0);
    x_a[1] = ref_elem(0, 1);
    x_a[2] = ref_elem(1, 0);
    x_a[3] = ref_elem(1, 1);
    x_err  = 1'b0;
  endtask

  // Drive m_b, check latency/outputs, hold DONE for 'hold' cycles with junk input.
  task automatic run_txn(input string tag, input int hold, input logic chk_data);
    int guard;
    int lat;
    u11 = m_b[0]; u12 = m_b[1]; u21 = m_b[2]; u22 = m_b[3];
    sigma1 = m_b[4]; sigma2 = m_b[5]; c = m_b[6]; s = m_b[7];
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 20) begin @(posedge aclk); #1; guard++; end
    check({tag, "_in_ready"}, in_ready, 1'b1);
    @(posedge aclk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge aclk); #1; lat++; end
    check({tag, "_latency"}, lat, 6);
    o_a[0] = a11; o_a[1] = a12; o_a[2] = a21; o_a[3] = a22;
    if (chk_data) begin
      check({tag, "_a11"}, a11, x_a[0]);
      check({tag, "_a12"}, a12, x_a[1]);
      check({tag, "_a21"}, a21, x_a[2]);
      check({tag, "_a22"}, a22, x_a[3]);
    end
    check({tag, "_err"}, err, x_err);
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      u11 = $urandom; sigma1 = $urandom; c = $urandom;
      @(posedge aclk); #1;
      check({tag, "_hold_valid"}, out_valid, 1'b1);
      check({tag, "_hold_ready"}, in_ready, 1'b0);
      check({tag, "_hold_a11"}, a11, o_a[0]);
      check({tag, "_hold_a22"}, a22, o_a[3]);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge aclk); #1;
    out_ready = 1'b0;
    check({tag, "_release"}, in_ready, 1'b1);
    check({tag, "_release_ov"}, out_valid, 1'b0);
  endtask

  task automatic load_scaling();
    m_b[0] = 32'h3F80_0000; m_b[1] = 32'h0; m_b[2] = 32'h0; m_b[3] = 32'h3F80_0000;
    m_b[4] = 32'h4000_0000; m_b[5] = 32'h4040_0000; m_b[6] = 32'h3F80_0000; m_b[7] = 32'h0;
    x_a[0] = 32'h4000_0000; x_a[1] = 32'h0; x_a[2] = 32'h0; x_a[3] = 32'h4040_0000;
    x_err  = 1'b0;
  endtask

  initial begin
    real orig [4];
    real tol, dv, r10;
    int  guard;
    logic ok;
    areset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    u11 = 0; u12 = 0; u21 = 0; u22 = 0; sigma1 = 0; sigma2 = 0; c = 0; s = 0;
    #12;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_a11", a11, 32'h0);
    check("rst_a12", a12, 32'h0);
    check("rst_a21", a21, 32'h0);
    check("rst_a22", a22, 32'h0);
    #10 areset = 1'b0;
    @(posedge aclk); #1;

    load_scaling();
    run_txn("scale", 0, 1'b1);

    m_b[0] = 32'h3F80_0000; m_b[1] = 32'h0; m_b[2] = 32'h0; m_b[3] = 32'h3F80_0000;
    m_b[4] = 32'h3F80_0000; m_b[5] = 32'h3F80_0000; m_b[6] = 32'h0; m_b[7] = 32'h3F80_0000;
    x_a[0] = 32'h0; x_a[1] = 32'hBF80_0000; x_a[2] = 32'h3F80_0000; x_a[3] = 32'h0;
    x_err  = 1'b0;
    run_txn("rotate", 0, 1'b1);

    load_scaling();
    run_txn("backpressure", 5, 1'b1);

    // Reset while in ROT2: 4 edges after the accepting edge.
    load_scaling();
    u11 = m_b[0]; u12 = m_b[1]; u21 = m_b[2]; u22 = m_b[3];
    sigma1 = m_b[4]; sigma2 = m_b[5]; c = m_b[6]; s = m_b[7];
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 20) begin @(posedge aclk); #1; guard++; end
    @(posedge aclk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge aclk);
    #2 areset = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_a11", a11, 32'h0);
    #1 areset = 1'b0;
    @(posedge aclk); #1;
    load_scaling();
    run_txn("after_rst", 0, 1'b1);

    // Non-finite sigma1
    load_scaling();
    m_b[4] = 32'h7FC0_0000;
`ifdef SVD_COMPOSE_NAN_CHECK_EN
    x_a[0] = 32'h7FC0_0000; x_a[1] = 32'h7FC0_0000; x_a[2] = 32'h7FC0_0000; x_a[3] = 32'h7FC0_0000;
    x_err  = 1'b1;
    run_txn("nan", 1, 1'b1);
`else
    x_err  = 1'b0;
    run_txn("nan", 1, 1'b0);
`endif

    // Random exact-arithmetic cases: quarter-integers in [-4, 4].
    for (int t = 0; t < 20; t++) begin
      for (int k = 0; k < 8; k++)
        m_b[k] = r2f(real'(int'($urandom_range(0, 32)) - 16) * 0.25);
      model_expect();
      run_txn("rand", int'($urandom_range(0, 3)), 1'b1);
    end

    // Round trip of A = [[3,0],[4,5]] from its exact SVD factors.
    r10 = $sqrt(10.0);
    m_b[0] = r2f(1.0 / r10);  m_b[1] = r2f(-3.0 / r10);
    m_b[2] = r2f(3.0 / r10);  m_b[3] = r2f(1.0 / r10);
    m_b[4] = r2f($sqrt(45.0)); m_b[5] = r2f($sqrt(5.0));
    m_b[6] = r2f(1.0 / $sqrt(2.0)); m_b[7] = r2f(-1.0 / $sqrt(2.0));
    x_err = 1'b0;
    run_txn("roundtrip", 0, 1'b0);
    orig[0] = 3.0; orig[1] = 0.0; orig[2] = 4.0; orig[3] = 5.0;
    tol = 4.0 / 2097152.0;   // 4 ulp at the matrix scale (ulp(5.0) = 2^-21)
    for (int k = 0; k < 4; k++) begin
      dv = f2r(o_a[k]) - orig[k];
      if (dv < 0.0) dv = -dv;
      ok = (o_a[k][30:23] != 8'hFF) && (dv <= tol);
      check($sformatf("roundtrip_a%0d_4ulp", k), ok, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
`default_nettype wire

// File: doc/svd_compose.md
SVD_COMPOSE -- requirements
Module: svd_compose

Interface
REQ-001 The block SHALL have no parameters; all words are IEEE-754 single precision.
REQ-002 aclk  input  1  sole clock, rising edge.
REQ-003 areset  input  1  reset, asynchronous and active-high.
REQ-004 in_valid  input  1  operand set valid.
REQ-005 in_ready  output  1  block can accept an operand set.
REQ-006 u11, u12, u21, u22  input  32 each  left singular vectors U.
REQ-007 sigma1, sigma2  input  32 each  singular values.
REQ-008 c, s  input  32 each  rotation; V = [[c, s], [-s, c]].
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 a11, a12, a21, a22  output  32 each  reconstructed A = U * diag(sigma1, sigma2) * V^T.
REQ-012 err  output  1  invalid-operand flag (see Configuration).

Function
REQ-013 Arithmetic SHALL use two shared F_mult instances and one F_add, with aclk tied 1'b0 (zero-latency combinational model).
- Negation of s SHALL be a sign-bit flip, never F_sub.
REQ-014 The FSM states SHALL be IDLE, SCALE0, SCALE1, ROT0, ROT1, ROT2, ROT3, DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; an edge with in_valid=1 in IDLE SHALL capture all eight inputs and go to SCALE0.
REQ-016 SCALE0 SHALL register w11=u11*sigma1 and w21=u21*sigma1; SCALE1 SHALL register w12=u12*sigma2 and w22=u22*sigma2.
REQ-017 Each ROTk state SHALL register exactly one output, in this order:
- ROT0: a11 = w11*c + w12*s
- ROT1: a12 = w11*(-s) + w12*c
- ROT2: a21 = w21*c + w22*s
- ROT3: a22 = w21*(-s) + w22*c
REQ-018 ROT3 SHALL go to DONE; out_valid SHALL be 1 exactly in DONE, i.e. 6 edges after the accepting edge.
REQ-019 In DONE, a11..a22 and err SHALL hold stable until an edge with out_ready=1, which SHALL return the FSM to IDLE.
REQ-020 in_valid SHALL be ignored outside IDLE; throughput SHALL be at most one result per 8 cycles.
REQ-021 a11..a22 SHALL hold their last value outside DONE; only registers named in REQ-016/017 SHALL update.

Reset
REQ-022 areset SHALL force the FSM to IDLE, in_ready=1, out_valid=0, err=0, and all data registers to 32'h0, asynchronously.
REQ-023 Reset in any state SHALL discard the in-flight operation; the first transaction after release SHALL be computed correctly.

Configuration
REQ-024 With SVD_COMPOSE_NAN_CHECK_EN defined:
- err SHALL be set in DONE if any captured input has exponent 8'hFF.
- When err is set, a11..a22 SHALL read 32'h7FC00000.
REQ-025 Without SVD_COMPOSE_NAN_CHECK_EN, err SHALL be tied 0, no check logic SHALL exist, and outputs SHALL be raw arithmetic results.

Verification
REQ-026 Scaling: U=I, sigma1=0x40000000, sigma2=0x40400000, c=0x3F800000, s=0 -> a11=0x40000000, a12=0, a21=0, a22=0x40400000; out_valid 6 edges after accept.
REQ-027 Rotation: U=I, sigma1=sigma2=0x3F800000, c=0, s=0x3F800000 -> a11=0, a12=0xBF800000, a21=0x3F800000, a22=0.
REQ-028 Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, new in_valid ignored; out_ready=1 -> in_ready=1 next cycle.
REQ-029 Reset mid-op: assert areset in ROT2 -> out_valid=0, in_ready=1 immediately; the REQ-026 stimulus afterwards gives the REQ-026 result.
REQ-030 NaN: sigma1=0x7FC00000 -> with macro, err=1 and all outputs 0x7FC00000; without macro, err=0.
REQ-031 Round trip: A=[[3,0],[4,5]] through jacobi_svd/svd_reconstruct, then this block -> each element within 4 ulp of the original.
